// File: rtl/busx_arbiter.sv
// Round-robin arbiter sharing one BusX near port among NUM_PORTS requesters.
// Define BUSX_ARBITER_TIMEOUT_EN to abort transactions the far side never answers.
module busx_arbiter #(
   parameter int unsigned NUM_PORTS = 4,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic                         i_clock,
   input  logic                         i_reset,
   input  logic [NUM_PORTS-1:0]         i_request,
   input  logic [NUM_PORTS-1:0]         i_rw,
   input  logic [NUM_PORTS*32-1:0]      i_address,
   input  logic [NUM_PORTS*32-1:0]      i_wdata,
   output logic [31:0]                  o_rdata,
   output logic [NUM_PORTS-1:0]         o_ready,
   output logic                         o_bus_request,
   output logic                         o_bus_rw,
   output logic [31:0]                  o_bus_address,
   output logic [31:0]                  o_bus_wdata,
   input  logic [31:0]                  i_bus_rdata,
   input  logic                         i_bus_ready,
   output logic [$clog2(NUM_PORTS)-1:0] o_grant,
   output logic                         o_busy,
   output logic                         o_timeout
);

   localparam int unsigned GrantW = $clog2(NUM_PORTS);
   localparam logic [NUM_PORTS-1:0] ReadyBase = {{(NUM_PORTS-1){1'b0}}, 1'b1};

   if (NUM_PORTS < 2 || NUM_PORTS > 8 || TIMEOUT < 2) begin : g_bad_params
      $error("busx_arbiter: NUM_PORTS must be 2..8 and TIMEOUT at least 2");
   end

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StRelease
   } state_e;

   state_e                 state_q, state_d;
   logic [GrantW-1:0]      last_q, last_d;
   logic [GrantW-1:0]      grant_q, grant_d;
   logic                   bus_request_q, bus_request_d;
   logic                   bus_rw_q, bus_rw_d;
   logic [31:0]            bus_address_q, bus_address_d;
   logic [31:0]            bus_wdata_q, bus_wdata_d;
   logic [31:0]            rdata_q, rdata_d;
   logic [NUM_PORTS-1:0]   ready_q, ready_d;
   logic                   timeout_q, timeout_d;

   logic                   pick_found;
   logic [GrantW-1:0]      pick;
   logic [GrantW+4:0]      pick_base;

`ifdef BUSX_ARBITER_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

   logic [CntW-1:0]        cnt_q, cnt_d;
`endif

   // Search upward from last+1 so the most recent winner is considered last.
   always_comb begin : p_pick
      logic [GrantW-1:0] cand;
      cand       = '0;
      pick_found = 1'b0;
      pick       = '0;
      for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
         cand = GrantW'((32'(last_q) + i) % NUM_PORTS);
         if (!pick_found && i_request[cand]) begin
            pick_found = 1'b1;
            pick       = cand;
         end
      end
   end

   assign pick_base = {pick, 5'b00000};

   always_comb begin
      state_d       = state_q;
      last_d        = last_q;
      grant_d       = grant_q;
      bus_request_d = bus_request_q;
      bus_rw_d      = bus_rw_q;
      bus_address_d = bus_address_q;
      bus_wdata_d   = bus_wdata_q;
      rdata_d       = rdata_q;
      ready_d       = '0;
      timeout_d     = timeout_q;
`ifdef BUSX_ARBITER_TIMEOUT_EN
      cnt_d         = cnt_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (pick_found) begin
               grant_d       = pick;
               last_d        = pick;
               bus_rw_d      = i_rw[pick];
               bus_address_d = i_address[pick_base +: 32];
               bus_wdata_d   = i_wdata[pick_base +: 32];
               bus_request_d = 1'b1;
               state_d       = StIssue;
`ifdef BUSX_ARBITER_TIMEOUT_EN
               cnt_d         = '0;
`endif
            end
         end

         StIssue: begin
`ifdef BUSX_ARBITER_TIMEOUT_EN
            cnt_d = cnt_q + 1'b1;
`endif
            if (i_bus_ready) begin
               rdata_d       = i_bus_rdata;
               ready_d       = ReadyBase << grant_q;
               bus_request_d = 1'b0;
               state_d       = StRelease;
            end
`ifdef BUSX_ARBITER_TIMEOUT_EN
            else if (cnt_q == CntLast) begin
               // Abort looks like a normal completion to the requester.
               rdata_d       = 32'hDEAD_BEEF;
               ready_d       = ReadyBase << grant_q;
               bus_request_d = 1'b0;
               timeout_d     = 1'b1;
               state_d       = StRelease;
            end
`endif
         end

         StRelease: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q       <= StIdle;
         last_q        <= GrantW'(NUM_PORTS - 1);
         grant_q       <= '0;
         bus_request_q <= 1'b0;
         bus_rw_q      <= 1'b0;
         bus_address_q <= '0;
         bus_wdata_q   <= '0;
         rdata_q       <= '0;
         ready_q       <= '0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_q        <= last_d;
         grant_q       <= grant_d;
         bus_request_q <= bus_request_d;
         bus_rw_q      <= bus_rw_d;
         bus_address_q <= bus_address_d;
         bus_wdata_q   <= bus_wdata_d;
         rdata_q       <= rdata_d;
         ready_q       <= ready_d;
         timeout_q     <= timeout_d;
      end
   end

`ifdef BUSX_ARBITER_TIMEOUT_EN
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_timeout = timeout_q;
`else
   assign o_timeout = 1'b0;
`endif

   assign o_rdata       = rdata_q;
   assign o_ready       = ready_q;
   assign o_bus_request = bus_request_q;
   assign o_bus_rw      = bus_rw_q;
   assign o_bus_address = bus_address_q;
   assign o_bus_wdata   = bus_wdata_q;
   assign o_grant       = grant_q;
   assign o_busy        = (state_q != StIdle);

endmodule
